// File: rtl/init_reg_bank_if.sv
// Bus bundle for init_reg_bank: write port, sweep request, read port and status.
// The valid vector exists only when INIT_BANK_VALID_EN is defined.
interface init_reg_bank_if #(
  parameter int WIDTH  = 3,
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 2
);
  logic              en;
  logic [ADDR_W-1:0] wr_addr;
  logic [WIDTH-1:0]  val;
  logic              init_start;
  logic [WIDTH-1:0]  init_val;
  logic [ADDR_W-1:0] rd_addr;
  logic [WIDTH-1:0]  rd_data;
  logic              busy;
  logic              done;
  logic              wr_err;
`ifdef INIT_BANK_VALID_EN
  logic [DEPTH-1:0]  valid;
`endif

  modport master (
`ifdef INIT_BANK_VALID_EN
    input  valid,
`endif
    output en, wr_addr, val, init_start, init_val, rd_addr,
    input  rd_data, busy, done, wr_err
  );

  modport slave (
`ifdef INIT_BANK_VALID_EN
    output valid,
`endif
    input  en, wr_addr, val, init_start, init_val, rd_addr,
    output rd_data, busy, done, wr_err
  );
endinterface

// File: rtl/init_reg_bank.sv
// DEPTH x WIDTH register bank with addressed writes, a one-entry-per-cycle init sweep
// and a combinational read. Define INIT_BANK_VALID_EN to add per-entry valid tracking.
module init_reg_bank_entry #(
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [WIDTH-1:0] d,
`ifdef INIT_BANK_VALID_EN
  output logic             vld,
`endif
  output logic [WIDTH-1:0] q
);
  always_ff @(posedge clk or posedge rst) begin
    if (rst)     q <= '0;
    else if (we) q <= d;
  end

`ifdef INIT_BANK_VALID_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)     vld <= 1'b0;
    else if (we) vld <= 1'b1;
  end
`endif
endmodule

module init_reg_bank #(
  parameter int WIDTH  = 3,
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 2
) (
  input logic           clk,
  input logic           rst,
  init_reg_bank_if.slave bus
);
  typedef enum logic [1:0] {IDLE, SWEEP, FIN} state_t;

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  state_t                       state;
  logic [ADDR_W-1:0]            ptr;
  logic [WIDTH-1:0]             sweep_val;
  logic                         busy, done, wr_err;
  logic [DEPTH-1:0]             hit, we;
  logic [DEPTH-1:0][WIDTH-1:0]  d, q;
  logic [WIDTH-1:0]             rd;
  logic                         wr_reject;
`ifdef INIT_BANK_VALID_EN
  logic [DEPTH-1:0]             vld;
`endif

  // During a sweep the sweep owns every entry; otherwise the write port does.
  for (genvar i = 0; i < DEPTH; i++) begin : g_entry
    assign hit[i] = (bus.wr_addr == ADDR_W'(i));
    assign we[i]  = (state == SWEEP) ? (ptr == ADDR_W'(i)) : (bus.en & hit[i]);
    assign d[i]   = (state == SWEEP) ? sweep_val : bus.val;

    init_reg_bank_entry #(.WIDTH(WIDTH)) u_entry (
      .clk (clk),
      .rst (rst),
      .we  (we[i]),
      .d   (d[i]),
`ifdef INIT_BANK_VALID_EN
      .vld (vld[i]),
`endif
      .q   (q[i])
    );
  end

  // An address matching no entry is out of range.
  assign wr_reject = bus.en & ((state == SWEEP) | ~|hit);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= '0;
      sweep_val <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      wr_err    <= 1'b0;
    end else begin
      wr_err <= wr_reject;
      done   <= 1'b0;
      case (state)
        IDLE: if (bus.init_start) begin
          sweep_val <= bus.init_val;
          ptr       <= '0;
          busy      <= 1'b1;
          state     <= SWEEP;
        end
        SWEEP: if (ptr == LAST) begin
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= FIN;
        end else begin
          ptr <= ptr + 1'b1;
        end
        FIN:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    rd = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (bus.rd_addr == ADDR_W'(i)) begin
`ifdef INIT_BANK_VALID_EN
        rd = q[i] & {WIDTH{vld[i]}};
`else
        rd = q[i];
`endif
      end
    end
  end

  assign bus.rd_data = rd;
  assign bus.busy    = busy;
  assign bus.done    = done;
  assign bus.wr_err  = wr_err;
`ifdef INIT_BANK_VALID_EN
  assign bus.valid   = vld;
`endif
endmodule
